// File: rtl/updown_counter_mod_pkg.sv
// Shared encodings for the up/down counter family: count direction and
// limit behaviour (wrap or saturate).
package updown_counter_mod_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

endpackage : updown_counter_mod_pkg

// File: rtl/updown_counter_mod.sv
// Parametrised modulo-(MAX_VAL+1) up/down counter with load, enable,
// wrap-or-saturate limits and a registered wrap pulse for cascading.
module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LP_ZERO = '0;
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_count == LP_MAX);
    assign w_at_min = (r_count == LP_ZERO);

    // Limits are detected by explicit compare so a non-power-of-2 MAX_VAL
    // never relies on natural WIDTH-bit overflow.
    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (load) begin
            w_next_count = (load_val > LP_MAX) ? LP_MAX : load_val;
        end else if (en) begin
            if (up_down == DIR_UP) begin
                if (!w_at_max) begin
                    w_next_count = r_count + LP_ONE;
                end else if (SATURATE != MODE_SAT) begin
                    w_next_count = LP_ZERO;
                    w_next_wrap  = 1'b1;
                end
            end else begin
                if (!w_at_min) begin
                    w_next_count = r_count - LP_ONE;
                end else if (SATURATE != MODE_SAT) begin
                    w_next_count = LP_MAX;
                    w_next_wrap  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= LP_ZERO;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign counter = r_count;
    assign wrap    = r_wrap;
    assign at_max  = w_at_max;
    assign at_min  = w_at_min;

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: directed vector table, hand-written corner
// sequences and a randomized run against an arithmetic reference model.
module tb_updown_counter_mod;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // DUT A: WIDTH=4, MAX_VAL=9, wrap
    logic       a_reset = 1'b0, a_en = 1'b0, a_dn = 1'b0, a_load = 1'b0;
    logic [3:0] a_lv = '0, a_cnt;
    logic       a_wrap, a_max, a_min;
    // DUT S: WIDTH=4, MAX_VAL=9, saturate
    logic       s_reset = 1'b0, s_en = 1'b0, s_dn = 1'b0, s_load = 1'b0;
    logic [3:0] s_lv = '0, s_cnt;
    logic       s_wrap, s_max, s_min;
    // DUT B: WIDTH=1, MAX_VAL=1, wrap
    logic       b_reset = 1'b0, b_en = 1'b0, b_dn = 1'b0, b_load = 1'b0;
    logic [0:0] b_lv = '0, b_cnt;
    logic       b_wrap, b_max, b_min;

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up_down(a_dn), .load(a_load),
        .load_val(a_lv), .counter(a_cnt), .wrap(a_wrap), .at_max(a_max), .at_min(a_min));
    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(s_reset), .en(s_en), .up_down(s_dn), .load(s_load),
        .load_val(s_lv), .counter(s_cnt), .wrap(s_wrap), .at_max(s_max), .at_min(s_min));
    updown_counter_mod #(.WIDTH(1), .MAX_VAL(1), .SATURATE(1'b0)) dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up_down(b_dn), .load(b_load),
        .load_val(b_lv), .counter(b_cnt), .wrap(b_wrap), .at_max(b_max), .at_min(b_min));

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_a(input bit r, input bit ld, input int lv, input bit en, input bit dn);
        a_reset = r; a_load = ld; a_lv = 4'(lv); a_en = en; a_dn = dn;
    endtask
    task automatic drive_s(input bit r, input bit ld, input int lv, input bit en, input bit dn);
        s_reset = r; s_load = ld; s_lv = 4'(lv); s_en = en; s_dn = dn;
    endtask
    task automatic drive_b(input bit r, input bit ld, input int lv, input bit en, input bit dn);
        b_reset = r; b_load = ld; b_lv = 1'(lv); b_en = en; b_dn = dn;
    endtask

    task automatic chk_s(input string tag, input int c, input bit w, input bit mx, input bit mn);
        chk({tag, " counter"}, int'(s_cnt), c);
        chk({tag, " wrap"},    int'(s_wrap), int'(w));
        chk({tag, " at_max"},  int'(s_max), int'(mx));
        chk({tag, " at_min"},  int'(s_min), int'(mn));
    endtask
    task automatic chk_b(input string tag, input int c, input bit w);
        chk({tag, " counter"}, int'(b_cnt), c);
        chk({tag, " wrap"},    int'(b_wrap), int'(w));
        chk({tag, " at_max"},  int'(b_max), int'(c == 1));
        chk({tag, " at_min"},  int'(b_min), int'(c == 0));
    endtask

    // ---------------- reference model ----------------
    // Counting is arithmetic modulo (maxv+1), or clamped to [0, maxv] when saturating.
    task automatic ref_step(input int maxv, input bit sat, input bit rst, input bit ld,
                            input int lv, input bit en, input bit dn,
                            inout int cnt, inout bit wr);
        wr = 1'b0;
        if (rst) begin
            cnt = 0;
        end else if (ld) begin
            cnt = (lv > maxv) ? maxv : lv;
        end else if (en && !dn) begin
            if (sat) cnt = (cnt + 1 > maxv) ? maxv : cnt + 1;
            else begin
                wr  = (cnt == maxv);
                cnt = (cnt + 1) % (maxv + 1);
            end
        end else if (en && dn) begin
            if (sat) cnt = (cnt - 1 < 0) ? 0 : cnt - 1;
            else begin
                wr  = (cnt == 0);
                cnt = (cnt + maxv) % (maxv + 1);
            end
        end
    endtask

    // ---------------- directed vector table (DUT A) ----------------
    typedef struct {
        bit       rst;
        bit       ld;
        int       lv;
        bit       en;
        bit       dn;
        int       exp_cnt;
        bit       exp_wrap;
        bit       exp_max;
        bit       exp_min;
    } vec_t;

    vec_t vec_q[$];

    task automatic add(input bit r, input bit ld, input int lv, input bit en, input bit dn,
                       input int c, input bit w);
        vec_t v;
        v.rst = r; v.ld = ld; v.lv = lv; v.en = en; v.dn = dn;
        v.exp_cnt = c; v.exp_wrap = w; v.exp_max = (c == 9); v.exp_min = (c == 0);
        vec_q.push_back(v);
    endtask

    initial begin
        int mc[3];
        bit mw[3];
        string tag;

        // Reset then 12 up-counts: 1..9, 0 (wrap), 1, 2
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) add(0, 0, 0, 1, 0, k % 10, k == 10);
        // wrap clears on the following idle cycle
        add(0, 0, 0, 0, 0, 2, 0);
        // Down wrap from 1
        add(0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 9, 1);
        add(0, 0, 0, 1, 1, 8, 0);
        // Load priority over en and clamp
        add(0, 1, 13, 1, 0, 9, 0);
        add(0, 1, 4, 0, 0, 4, 0);
        add(0, 1, 15, 1, 1, 9, 0);
        add(0, 1, 9, 1, 0, 9, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 1, 0, 0);
        // Hold, then reset beats load and en
        add(0, 1, 6, 0, 0, 6, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 6, 0);
        add(1, 1, 7, 1, 0, 0, 0);
        // Reset during a wrap edge suppresses the wrap pulse
        add(0, 1, 9, 0, 0, 9, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        // Direction toggle every cycle from 5
        add(0, 1, 5, 0, 0, 5, 0);
        add(0, 0, 0, 1, 0, 6, 0);
        add(0, 0, 0, 1, 1, 5, 0);
        add(0, 0, 0, 1, 0, 6, 0);
        add(0, 0, 0, 1, 1, 5, 0);

        tick();
        foreach (vec_q[i]) begin
            drive_a(vec_q[i].rst, vec_q[i].ld, vec_q[i].lv, vec_q[i].en, vec_q[i].dn);
            tick();
            tag = $sformatf("vec%0d", i);
            chk({tag, " counter"}, int'(a_cnt), vec_q[i].exp_cnt);
            chk({tag, " wrap"},    int'(a_wrap), int'(vec_q[i].exp_wrap));
            chk({tag, " at_max"},  int'(a_max), int'(vec_q[i].exp_max));
            chk({tag, " at_min"},  int'(a_min), int'(vec_q[i].exp_min));
        end
        drive_a(0, 0, 0, 0, 0);

        // ---------------- saturate sequence ----------------
        drive_s(1, 0, 0, 0, 0); tick(); chk_s("sat reset", 0, 0, 0, 1);
        drive_s(0, 1, 7, 0, 0); tick(); chk_s("sat load7", 7, 0, 0, 0);
        drive_s(0, 0, 0, 1, 0);
        tick(); chk_s("sat up1", 8, 0, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            tick(); chk_s($sformatf("sat up%0d", k), 9, 0, 1, 0);
        end
        drive_s(0, 1, 1, 0, 0); tick(); chk_s("sat load1", 1, 0, 0, 0);
        drive_s(0, 0, 0, 1, 1);
        tick(); chk_s("sat dn1", 0, 0, 0, 1);
        tick(); chk_s("sat dn2", 0, 0, 0, 1);
        drive_s(0, 0, 0, 0, 0);

        // ---------------- WIDTH=1 sequence ----------------
        drive_b(1, 0, 0, 0, 0); tick(); chk_b("w1 reset", 0, 0);
        drive_b(0, 0, 0, 1, 0);
        tick(); chk_b("w1 up1", 1, 0);
        tick(); chk_b("w1 up2", 0, 1);
        tick(); chk_b("w1 up3", 1, 0);
        tick(); chk_b("w1 up4", 0, 1);
        drive_b(0, 0, 0, 1, 1);
        tick(); chk_b("w1 dn1", 1, 1);
        tick(); chk_b("w1 dn2", 0, 0);
        tick(); chk_b("w1 dn3", 1, 1);
        drive_b(0, 0, 0, 0, 0);

        // ---------------- randomized run vs model ----------------
        drive_a(1, 0, 0, 0, 0); drive_s(1, 0, 0, 0, 0); drive_b(1, 0, 0, 0, 0);
        tick();
        for (int j = 0; j < 3; j++) begin mc[j] = 0; mw[j] = 1'b0; end
        for (int n = 0; n < 400; n++) begin
            bit r[3], ld[3], en[3], dn[3];
            int lv[3];
            for (int j = 0; j < 3; j++) begin
                r[j]  = ($urandom_range(0, 39) == 0);
                ld[j] = ($urandom_range(0, 9) == 0);
                lv[j] = (j == 2) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
                en[j] = ($urandom_range(0, 3) != 0);
                dn[j] = (n % 50 < 25) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
            end
            drive_a(r[0], ld[0], lv[0], en[0], dn[0]);
            drive_s(r[1], ld[1], lv[1], en[1], dn[1]);
            drive_b(r[2], ld[2], lv[2], en[2], dn[2]);
            tick();
            ref_step(9, 0, r[0], ld[0], lv[0], en[0], dn[0], mc[0], mw[0]);
            ref_step(9, 1, r[1], ld[1], lv[1], en[1], dn[1], mc[1], mw[1]);
            ref_step(1, 0, r[2], ld[2], lv[2], en[2], dn[2], mc[2], mw[2]);
            chk("rnd A counter", int'(a_cnt), mc[0]);
            chk("rnd A wrap",    int'(a_wrap), int'(mw[0]));
            chk("rnd A at_max",  int'(a_max), int'(mc[0] == 9));
            chk("rnd A at_min",  int'(a_min), int'(mc[0] == 0));
            chk_s("rnd S", mc[1], mw[1], mc[1] == 9, mc[1] == 0);
            chk_b("rnd B", mc[2], mw[2]);
        end

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_updown_counter_mod
